// File: rtl/toll_lane_controller.sv
// Toll lane controller: prices a vehicle request, debits the tag balance, raises the gate and tallies lane statistics.
// Latency: the response strobe rises on the second edge counting the accepting edge; one request per 3 cycles at best.
// Backpressure: req_ready is high only while idle and enabled; requests offered while busy are not accepted.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   enable                lane open; only gates new acceptances
//   req_valid/req_ready   request handshake carrying vehicle_type, balance, peak_mode
//   vehicle_passed        vehicle cleared the gate (only honoured while the gate is up)
//   resp_valid            one-cycle strobe with toll_fee, updated_balance, reject (held until the next response)
//   gate_open             barrier raised
//   revenue               saturating sum of debited fees
//   vehicle_count         vehicles that passed (wraps)
//   reject_count          rejected requests (wraps)
//   timeout_flag          sticky: a raised gate timed out without a pass
module toll_lane_controller #(
  parameter int BAL_W        = 8,
  parameter int FEE_BIKE     = 5,
  parameter int FEE_CAR      = 10,
  parameter int FEE_BUS      = 15,
  parameter int FEE_TRUCK    = 20,
  parameter int GATE_TIMEOUT = 16,
  parameter int REV_W        = 16,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       vehicle_type,
  input  logic [BAL_W-1:0] balance,
  input  logic             peak_mode,
  input  logic             vehicle_passed,
  output logic             resp_valid,
  output logic [BAL_W-1:0] toll_fee,
  output logic [BAL_W-1:0] updated_balance,
  output logic             reject,
  output logic             gate_open,
  output logic [REV_W-1:0] revenue,
  output logic [CNT_W-1:0] vehicle_count,
  output logic [CNT_W-1:0] reject_count,
  output logic             timeout_flag
);

  typedef enum logic [1:0] {IDLE, CALC, RESP, GATE} state_t;

  localparam int TMR_W = $clog2(GATE_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_TIMEOUT - 1);
  // Revenue sum is formed wide enough for either operand plus a carry.
  localparam int SUM_W = ((REV_W > BAL_W) ? REV_W : BAL_W) + 1;
  localparam logic [SUM_W-1:0] REV_MAX = (SUM_W'(1) << REV_W) - SUM_W'(1);

  state_t           state_q;
  logic [1:0]       type_q;
  logic [BAL_W-1:0] bal_q;
  logic             peak_q;
  logic [TMR_W-1:0] tmr_q;
  logic             resp_valid_q;
  logic [BAL_W-1:0] toll_fee_q;
  logic [BAL_W-1:0] upd_bal_q;
  logic             reject_q;
  logic             gate_open_q;
  logic [REV_W-1:0] revenue_q;
  logic [CNT_W-1:0] vcnt_q;
  logic [CNT_W-1:0] rcnt_q;
  logic             tflag_q;

  logic [BAL_W:0]   base_fee;
  logic [BAL_W:0]   fee_sum;
  logic [BAL_W-1:0] fee_d;
  logic [SUM_W-1:0] rev_sum;
  logic [REV_W-1:0] revenue_d;

  // Pricing works on the latched request so the inputs are free to change after acceptance.
  always_comb begin
    base_fee = '0;
    case (type_q)
      2'b00:   base_fee = (BAL_W+1)'(FEE_BIKE);
      2'b01:   base_fee = (BAL_W+1)'(FEE_CAR);
      2'b10:   base_fee = (BAL_W+1)'(FEE_BUS);
      default: base_fee = (BAL_W+1)'(FEE_TRUCK);
    endcase
    fee_sum   = base_fee + (peak_q ? (base_fee >> 1) : '0);
    fee_d     = fee_sum[BAL_W] ? '1 : fee_sum[BAL_W-1:0];
    rev_sum   = SUM_W'(revenue_q) + SUM_W'(fee_d);
    revenue_d = (rev_sum > REV_MAX) ? '1 : rev_sum[REV_W-1:0];
  end

  // Gated by reset so the lane never advertises readiness while held in reset.
  assign req_ready = (state_q == IDLE) && enable && reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      type_q       <= '0;
      bal_q        <= '0;
      peak_q       <= 1'b0;
      tmr_q        <= '0;
      resp_valid_q <= 1'b0;
      toll_fee_q   <= '0;
      upd_bal_q    <= '0;
      reject_q     <= 1'b0;
      gate_open_q  <= 1'b0;
      revenue_q    <= '0;
      vcnt_q       <= '0;
      rcnt_q       <= '0;
      tflag_q      <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready) begin
            type_q  <= vehicle_type;
            bal_q   <= balance;
            peak_q  <= peak_mode;
            state_q <= CALC;
          end
        end
        CALC: begin
          toll_fee_q   <= fee_d;
          resp_valid_q <= 1'b1;
          if (fee_d > bal_q) begin
            reject_q  <= 1'b1;
            upd_bal_q <= bal_q;
            rcnt_q    <= rcnt_q + CNT_W'(1);
            state_q   <= RESP;
          end else begin
            reject_q    <= 1'b0;
            upd_bal_q   <= bal_q - fee_d;
            revenue_q   <= revenue_d;
            gate_open_q <= 1'b1;
            tmr_q       <= '0;
            state_q     <= GATE;
          end
        end
        RESP: state_q <= IDLE;
        GATE: begin
          // A pass on the timeout edge still counts as a pass.
          if (vehicle_passed) begin
            gate_open_q <= 1'b0;
            vcnt_q      <= vcnt_q + CNT_W'(1);
            state_q     <= IDLE;
          end else if (tmr_q == TMR_LAST) begin
            gate_open_q <= 1'b0;
            tflag_q     <= 1'b1;
            state_q     <= IDLE;
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign resp_valid      = resp_valid_q;
  assign toll_fee        = toll_fee_q;
  assign updated_balance = upd_bal_q;
  assign reject          = reject_q;
  assign gate_open       = gate_open_q;
  assign revenue         = revenue_q;
  assign vehicle_count   = vcnt_q;
  assign reject_count    = rcnt_q;
  assign timeout_flag    = tflag_q;

endmodule

// File: tb/tb_toll_lane_controller.sv
module tb_toll_lane_controller;

  localparam int BAL_W = 8;
  localparam int REV_W = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       vehicle_type;
  logic [BAL_W-1:0] balance;
  logic             peak_mode;
  logic             vehicle_passed;
  logic             resp_valid;
  logic [BAL_W-1:0] toll_fee;
  logic [BAL_W-1:0] updated_balance;
  logic             reject;
  logic             gate_open;
  logic [REV_W-1:0] revenue;
  logic [CNT_W-1:0] vehicle_count;
  logic [CNT_W-1:0] reject_count;
  logic             timeout_flag;

  always #5 clk = ~clk;

  toll_lane_controller #(.BAL_W(BAL_W), .REV_W(REV_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .req_valid(req_valid), .req_ready(req_ready),
    .vehicle_type(vehicle_type), .balance(balance), .peak_mode(peak_mode),
    .vehicle_passed(vehicle_passed), .resp_valid(resp_valid),
    .toll_fee(toll_fee), .updated_balance(updated_balance), .reject(reject),
    .gate_open(gate_open), .revenue(revenue), .vehicle_count(vehicle_count),
    .reject_count(reject_count), .timeout_flag(timeout_flag)
  );

  typedef struct {
    logic [1:0] vt;
    logic [7:0] bal;
    logic       peak;
    logic [7:0] fee;
    logic [7:0] upd;
    logic       rej;
    int         pass_at;   // GATE edges to let elapse before the pass is sampled; -1 = no pass
    bit         drop_en;   // drop enable while the request is being priced
  } vec_t;

  typedef struct {
    logic [7:0] fee;
    logic [7:0] upd;
    logic       rej;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;
  vec_t vecs[6];
  vec_t v;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   m_rev  = 0;
  int   m_vcnt = 0;
  int   m_rcnt = 0;
  int   m_tflag = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mkv(input logic [1:0] vt, input logic [7:0] bal, input logic peak,
                               input logic [7:0] fee, input logic [7:0] upd, input logic rej,
                               input int pass_at, input bit drop_en);
    vec_t r;
    r.vt = vt; r.bal = bal; r.peak = peak; r.fee = fee; r.upd = upd; r.rej = rej;
    r.pass_at = pass_at; r.drop_en = drop_en;
    return r;
  endfunction

  // Scoreboard: every response strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset === 1'b1 && resp_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_resp: got resp_valid 1 expected 0 (t=%0t)", $time);
      end else begin
        sb_e = sb_q.pop_front();
        chk("sb_toll_fee", toll_fee, sb_e.fee);
        chk("sb_updated_balance", updated_balance, sb_e.upd);
        chk("sb_reject", reject, sb_e.rej);
      end
    end
  end

  task automatic check_zero_outs(input string tag);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_toll_fee"}, toll_fee, 0);
    chk({tag, "_updated_balance"}, updated_balance, 0);
    chk({tag, "_reject"}, reject, 0);
    chk({tag, "_gate_open"}, gate_open, 0);
    chk({tag, "_revenue"}, revenue, 0);
    chk({tag, "_vehicle_count"}, vehicle_count, 0);
    chk({tag, "_reject_count"}, reject_count, 0);
    chk({tag, "_timeout_flag"}, timeout_flag, 0);
  endtask

  task automatic txn(input vec_t t);
    @(negedge clk);
    vehicle_type = t.vt; balance = t.bal; peak_mode = t.peak; req_valid = 1'b1;
    chk("req_ready_idle", req_ready, 1);
    sb_q.push_back('{t.fee, t.upd, t.rej});
    @(negedge clk);                       // accepting edge has passed: pricing cycle
    req_valid = 1'b0;
    vehicle_type = ~t.vt; balance = ~t.bal; peak_mode = ~t.peak;
    if (t.drop_en) enable = 1'b0;
    chk("calc_resp_valid", resp_valid, 0);
    chk("calc_req_ready", req_ready, 0);
    @(negedge clk);                       // second edge: response strobe
    chk("latency_resp_valid", resp_valid, 1);
    enable = 1'b1;
    if (t.rej) begin
      m_rcnt++;
      chk("rej_gate_open", gate_open, 0);
      chk("rej_reject_count", reject_count, m_rcnt);
      chk("rej_revenue", revenue, m_rev);
      @(negedge clk);
      chk("rej_resp_one_cycle", resp_valid, 0);
      chk("rej_hold_reject", reject, 1);
      chk("rej_back_idle", req_ready, 1);
    end else begin
      m_rev = (m_rev + t.fee > 15) ? 15 : m_rev + t.fee;
      chk("acc_revenue", revenue, m_rev);
      chk("acc_gate_open", gate_open, 1);
      if (t.pass_at >= 0) begin
        repeat (t.pass_at) @(negedge clk);
        chk("acc_gate_still_open", gate_open, 1);
        vehicle_passed = 1'b1;
        @(negedge clk);
        vehicle_passed = 1'b0;
        m_vcnt++;
        chk("pass_gate_open", gate_open, 0);
        chk("pass_vehicle_count", vehicle_count, m_vcnt);
        chk("pass_timeout_flag", timeout_flag, m_tflag);
        chk("pass_back_idle", req_ready, 1);
        chk("pass_hold_fee", toll_fee, t.fee);
        chk("pass_hold_upd", updated_balance, t.upd);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // type, bal, peak, fee, upd, rej, pass_at, drop_en
    vecs[0] = mkv(2'b01, 8'd20,  1'b0, 8'd10, 8'd10,  1'b0, 2,  1'b0); // car off-peak
    vecs[1] = mkv(2'b11, 8'd10,  1'b0, 8'd20, 8'd10,  1'b1, -1, 1'b0); // truck short of funds
    vecs[2] = mkv(2'b10, 8'd22,  1'b1, 8'd22, 8'd0,   1'b0, 0,  1'b1); // bus peak, fee == balance
    vecs[3] = mkv(2'b00, 8'd3,   1'b1, 8'd7,  8'd3,   1'b1, -1, 1'b0); // bike peak rejected
    vecs[4] = mkv(2'b11, 8'd255, 1'b1, 8'd30, 8'd225, 1'b0, 15, 1'b0); // pass on the timeout edge
    vecs[5] = mkv(2'b01, 8'd10,  1'b0, 8'd10, 8'd0,   1'b0, 1,  1'b0); // car exact balance

    reset = 1'b0; enable = 1'b1; req_valid = 1'b0; vehicle_type = '0;
    balance = '0; peak_mode = 1'b0; vehicle_passed = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    check_zero_outs("rst");
    reset = 1'b1;
    #1;
    chk("rel_req_ready", req_ready, 1);
    check_zero_outs("rel");

    // Lane closed: requests are not taken.
    @(negedge clk);
    enable = 1'b0;
    vehicle_type = 2'b01; balance = 8'd50; req_valid = 1'b1;
    #1 chk("dis_req_ready", req_ready, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("dis_resp_valid", resp_valid, 0);
      chk("dis_gate_open", gate_open, 0);
    end
    req_valid = 1'b0;
    enable = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) txn(vecs[i]);

    // vehicle_passed while idle must not count.
    @(negedge clk);
    vehicle_passed = 1'b1;
    repeat (2) @(negedge clk);
    vehicle_passed = 1'b0;
    chk("idle_pass_count", vehicle_count, m_vcnt);
    chk("idle_pass_gate", gate_open, 0);

    // Gate timeout: bike accepted, nobody passes.
    v = mkv(2'b00, 8'd9, 1'b0, 8'd5, 8'd4, 1'b0, -1, 1'b0);
    txn(v);
    repeat (15) @(negedge clk);
    chk("tmo_gate_before", gate_open, 1);
    chk("tmo_flag_before", timeout_flag, 0);
    @(negedge clk);
    m_tflag = 1;
    chk("tmo_gate_open", gate_open, 0);
    chk("tmo_flag", timeout_flag, 1);
    chk("tmo_vehicle_count", vehicle_count, m_vcnt);
    chk("tmo_back_idle", req_ready, 1);

    // Sticky flag survives a normal transaction.
    v = mkv(2'b01, 8'd40, 1'b0, 8'd10, 8'd30, 1'b0, 3, 1'b0);
    txn(v);

    // Reset while the gate is up.
    v = mkv(2'b01, 8'd50, 1'b0, 8'd10, 8'd40, 1'b0, -1, 1'b0);
    txn(v);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("gate_rst_req_ready", req_ready, 0);
    check_zero_outs("gate_rst");
    m_rev = 0; m_vcnt = 0; m_rcnt = 0; m_tflag = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1 chk("gate_rel_req_ready", req_ready, 1);

    // Revenue saturates in the 4-bit accumulator.
    v = mkv(2'b01, 8'd20, 1'b0, 8'd10, 8'd10, 1'b0, 1, 1'b0);
    txn(v);
    txn(v);
    chk("rev_saturated", revenue, 15);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/toll_lane_controller.md
TOLL_LANE_CONTROLLER -- requirements
Module: toll_lane_controller

Parameters
REQ-001 The block SHALL have parameter BAL_W, default 8: width of balance, fee and updated_balance.
REQ-002 The block SHALL have parameters FEE_BIKE, FEE_CAR, FEE_BUS, FEE_TRUCK, defaults 5, 10, 15, 20: base fee per vehicle class.
REQ-003 The block SHALL have parameter GATE_TIMEOUT, default 16: maximum gate-open cycles without vehicle_passed.
REQ-004 The block SHALL have parameters REV_W, default 16, and CNT_W, default 8: widths of the revenue and count outputs.

Interface
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset; the ports are clk and reset.
REQ-006 The block SHALL have these ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-low reset
- enable  input  1  lane open; gates new acceptances only
- req_valid  input  1  vehicle request present
- req_ready  output  1  lane can accept a request
- vehicle_type  input  2  00 bike, 01 car, 10 bus, 11 truck
- balance  input  BAL_W  tag balance
- peak_mode  input  1  apply peak surcharge
- vehicle_passed  input  1  vehicle cleared the gate
- resp_valid  output  1  one-cycle response strobe
- toll_fee  output  BAL_W  fee charged or quoted
- updated_balance  output  BAL_W  balance after debit
- reject  output  1  insufficient balance
- gate_open  output  1  barrier raised
- revenue  output  REV_W  accumulated debits
- vehicle_count  output  CNT_W  vehicles passed
- reject_count  output  CNT_W  rejected requests
- timeout_flag  output  1  sticky gate-timeout indicator

Function
REQ-007 The FSM SHALL have states IDLE, CALC, RESP and GATE.
REQ-008 req_ready SHALL equal (state==IDLE && enable).
REQ-009 A request SHALL be accepted on a rising edge with req_valid && req_ready, SHALL latch vehicle_type, balance and peak_mode, and SHALL move the FSM to CALC.
REQ-010 Inputs other than vehicle_passed SHALL be ignored outside IDLE.
REQ-011 Deasserting enable mid-transaction SHALL NOT abort the transaction.
REQ-012 The fee SHALL be the base fee when peak_mode=0, and base + (base>>1) when peak_mode=1.
REQ-013 The fee SHALL be computed in BAL_W+1 bits and saturated to 2^BAL_W-1.
REQ-014 On the edge leaving CALC, toll_fee SHALL be registered and resp_valid SHALL be set to 1 for exactly one cycle.
REQ-015 If fee > balance, the block SHALL set reject=1, updated_balance=balance, reject_count+1 (wrapping), and move to RESP.
REQ-016 If fee <= balance (fee==balance is accepted, leaving updated_balance=0), the block SHALL set reject=0, updated_balance=balance-fee, revenue+=fee (saturating at 2^REV_W-1), gate_open=1, and move to GATE.
REQ-017 The FSM SHALL move from RESP to IDLE on the next edge.
REQ-018 toll_fee, updated_balance and reject SHALL hold their values until the next response.
REQ-019 In GATE, vehicle_passed=1 sampled on an edge SHALL clear gate_open, increment vehicle_count (wrapping), and move the FSM to IDLE.
REQ-020 In GATE, a cycle counter SHALL clear on entry; if GATE_TIMEOUT edges elapse without vehicle_passed, the block SHALL clear gate_open, set timeout_flag, leave vehicle_count unchanged, and move to IDLE.
REQ-021 If vehicle_passed coincides with the timeout edge, vehicle_passed SHALL take priority and timeout_flag SHALL NOT be set.
REQ-022 vehicle_passed outside GATE SHALL be ignored.
REQ-023 timeout_flag SHALL clear only on reset.
REQ-024 Latency from the accepting edge to resp_valid SHALL be exactly 2 edges; throughput SHALL be one request per 3 cycles minimum.

Reset
REQ-025 reset=0 SHALL immediately force the FSM to IDLE and drive every output to 0: gate_open, resp_valid, reject, toll_fee, updated_balance, revenue, vehicle_count, reject_count, timeout_flag.
REQ-026 During reset=0, req_ready SHALL be 0; after release it SHALL equal enable.
REQ-027 Reset asserted mid-transaction SHALL abandon the transaction with no counter or revenue update.

Verification
REQ-028 The bench SHALL cover reset and enable: hold reset=0, then release with enable=1 -> all outputs 0, req_ready=1; with enable=0 -> req_valid ignored, req_ready=0.
REQ-029 The bench SHALL cover a normal car transaction: car, balance 20, off-peak -> resp_valid 2 edges after accept, fee 10, updated 10, reject 0, gate_open 1; vehicle_passed -> gate_open 0, vehicle_count 1, revenue 10.
REQ-030 The bench SHALL cover an insufficient-balance truck: truck, balance 10 -> fee 20, updated 10, reject 1, gate_open stays 0, reject_count 1, revenue unchanged.
REQ-031 The bench SHALL cover the peak-fee equality boundary: bus, peak, balance 22 -> fee 22, updated 0, reject 0.
REQ-032 The bench SHALL cover timeout and mid-GATE reset: bike accepted, no vehicle_passed for 16 cycles -> gate_open drops, timeout_flag 1, vehicle_count unchanged; reset=0 during GATE -> gate_open 0 immediately, counters 0.
REQ-033 The bench SHALL cover revenue saturation: with REV_W=4, two car passes -> revenue saturates at 15.
